alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational
// ALU, with a single registered response slot (EMPTY/FULL).
// Optional build macro ALU_ARB_STATS_EN adds saturating 16-bit per-requester
// grant counters (o_grant_cnt0 / o_grant_cnt1).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1; ready never depends on the state of that requester's own valid beyond
// arbitration, and a response is consumed on a rising edge where o_rsp_valid
// and i_rsp_ready are both 1.
module alu_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [3:0]  i_req0_opcode,
    input  logic [31:0] i_req0_wordA,
    input  logic [31:0] i_req0_wordB,
    input  logic [4:0]  i_req0_shamt,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [3:0]  i_req1_opcode,
    input  logic [31:0] i_req1_wordA,
    input  logic [31:0] i_req1_wordB,
    input  logic [4:0]  i_req1_shamt,
    output logic [3:0]  o_alu_opcode,
    output logic [31:0] o_alu_wordA,
    output logic [31:0] o_alu_wordB,
    output logic [4:0]  o_alu_shamt,
    input  logic [31:0] i_alu_result,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] o_grant_cnt0,
    output logic [15:0] o_grant_cnt1
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_ptr;
    logic [31:0] r_data;
    logic        r_id;
    logic        w_sel;
    logic        w_slot_free;
    logic        w_grant;

    // Arbitration: pick the requester, decide whether the slot can accept it.
    // Reset is folded in so readies and ALU operands drop immediately.
    always_comb begin
        w_sel       = 1'b0;
        w_slot_free = 1'b0;
        w_grant     = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            w_sel = ~r_ptr;
        end else begin
            w_sel = i_req1_valid;
        end
        w_slot_free = (r_state == ST_EMPTY) || i_rsp_ready;
        w_grant     = i_rst_n && (i_req0_valid || i_req1_valid) && w_slot_free;
    end

    // Readies and the operand mux onto the shared ALU (all-zero without a grant).
    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_alu_opcode = 4'd0;
        o_alu_wordA  = 32'd0;
        o_alu_wordB  = 32'd0;
        o_alu_shamt  = 5'd0;
        if (w_grant) begin
            if (w_sel) begin
                o_req1_ready = 1'b1;
                o_alu_opcode = i_req1_opcode;
                o_alu_wordA  = i_req1_wordA;
                o_alu_wordB  = i_req1_wordB;
                o_alu_shamt  = i_req1_shamt;
            end else begin
                o_req0_ready = 1'b1;
                o_alu_opcode = i_req0_opcode;
                o_alu_wordA  = i_req0_wordA;
                o_alu_wordB  = i_req0_wordB;
                o_alu_shamt  = i_req0_shamt;
            end
        end
    end

    // Response slot next state: a grant always fills, a drain without grant empties.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_next_state = ST_FULL;
            ST_FULL: begin
                if (w_grant) begin
                    w_next_state = ST_FULL;
                end else if (i_rsp_ready) begin
                    w_next_state = ST_EMPTY;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    // State register, round-robin pointer and captured response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= 1'b1;
            r_data  <= 32'd0;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_ptr  <= w_sel;
                r_data <= i_alu_result;
                r_id   <= w_sel;
            end
        end
    end

    assign o_rsp_valid = (r_state == ST_FULL);
    assign o_rsp_data  = r_data;
    assign o_rsp_id    = r_id;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Saturating per-requester transfer counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt0 <= 16'd0;
            r_cnt1 <= 16'd0;
        end else if (w_grant) begin
            if (!w_sel && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_sel && (r_cnt1 != 16'hFFFF))  r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign o_grant_cnt0 = r_cnt0;
    assign o_grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of the arbiter and response slot.
// Build with ALU_ARB_STATS_EN defined to also check the grant counters.
`timescale 1ns/1ps
module tb_alu_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [3:0]  i_req0_opcode, i_req1_opcode;
    logic [31:0] i_req0_wordA, i_req0_wordB, i_req1_wordA, i_req1_wordB;
    logic [4:0]  i_req0_shamt, i_req1_shamt;
    logic [3:0]  o_alu_opcode;
    logic [31:0] o_alu_wordA, o_alu_wordB;
    logic [4:0]  o_alu_shamt;
    logic [31:0] i_alu_result;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_id;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] o_grant_cnt0, o_grant_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        m_full;
    logic [31:0] m_data;
    int          m_id;
    int          m_last;
    int          m_cnt0, m_cnt1;

    alu_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_opcode(i_req0_opcode), .i_req0_wordA(i_req0_wordA),
        .i_req0_wordB(i_req0_wordB), .i_req0_shamt(i_req0_shamt),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_opcode(i_req1_opcode), .i_req1_wordA(i_req1_wordA),
        .i_req1_wordB(i_req1_wordB), .i_req1_shamt(i_req1_shamt),
        .o_alu_opcode(o_alu_opcode), .o_alu_wordA(o_alu_wordA),
        .o_alu_wordB(o_alu_wordB), .o_alu_shamt(o_alu_shamt),
        .i_alu_result(i_alu_result),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_id(o_rsp_id)
`ifdef ALU_ARB_STATS_EN
        , .o_grant_cnt0(o_grant_cnt0), .o_grant_cnt1(o_grant_cnt1)
`endif
    );

    // clock / reset block
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // the shared ALU itself lives outside the DUT
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            default: return ~a + {28'd0, op};
        endcase
    endfunction

    assign i_alu_result = ref_alu(o_alu_opcode, o_alu_wordA, o_alu_wordB, o_alu_shamt);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic set_req(input int n, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        if (n == 0) begin
            i_req0_valid = v; i_req0_opcode = op; i_req0_wordA = a;
            i_req0_wordB = b; i_req0_shamt = sh;
        end else begin
            i_req1_valid = v; i_req1_opcode = op; i_req1_wordA = a;
            i_req1_wordB = b; i_req1_shamt = sh;
        end
    endtask

    task automatic rand_req(input int n, input logic v);
        set_req(n, v, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    endtask

    // One clock of traffic: check arbitration mid-cycle, then the response after the edge.
    task automatic step(input logic rr);
        int          win;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        logic [4:0]  e_sh;
        i_rsp_ready = rr;
        @(negedge i_clk);
        win = -1;
        if (!m_full || rr) begin
            if (i_req0_valid && i_req1_valid) win = (m_last == 0) ? 1 : 0;
            else if (i_req0_valid)            win = 0;
            else if (i_req1_valid)            win = 1;
        end
        e_op = 4'd0; e_a = 32'd0; e_b = 32'd0; e_sh = 5'd0;
        if (win == 0) begin
            e_op = i_req0_opcode; e_a = i_req0_wordA; e_b = i_req0_wordB; e_sh = i_req0_shamt;
        end else if (win == 1) begin
            e_op = i_req1_opcode; e_a = i_req1_wordA; e_b = i_req1_wordB; e_sh = i_req1_shamt;
        end
        chk("ready0", 32'(o_req0_ready), 32'(win == 0));
        chk("ready1", 32'(o_req1_ready), 32'(win == 1));
        chk("alu_opcode", 32'(o_alu_opcode), 32'(e_op));
        chk("alu_wordA", o_alu_wordA, e_a);
        chk("alu_wordB", o_alu_wordB, e_b);
        chk("alu_shamt", 32'(o_alu_shamt), 32'(e_sh));
        @(posedge i_clk);
        #1;
        if (win >= 0) begin
            m_full = 1'b1;
            m_data = ref_alu(e_op, e_a, e_b, e_sh);
            m_id   = win;
            m_last = win;
            if (win == 0 && m_cnt0 < 65535) m_cnt0++;
            if (win == 1 && m_cnt1 < 65535) m_cnt1++;
        end else if (rr) begin
            m_full = 1'b0;
        end
        chk("rsp_valid", 32'(o_rsp_valid), 32'(m_full));
        if (m_full) begin
            chk("rsp_data", o_rsp_data, m_data);
            chk("rsp_id", 32'(o_rsp_id), 32'(m_id));
        end
    endtask

    // Assert reset off-edge with both requesters pending, check the immediate effect.
    task automatic do_reset();
        #2;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1, 5'd0);
        set_req(1, 1'b1, 4'd0, 32'd2, 32'd2, 5'd0);
        i_rsp_ready = 1'b1;
        i_rst_n = 1'b0;
        #1;
        m_full = 1'b0; m_data = 32'd0; m_id = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_data", o_rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(o_rsp_id), 32'd0);
        chk("rst_ready0", 32'(o_req0_ready), 32'd0);
        chk("rst_ready1", 32'(o_req1_ready), 32'd0);
        chk("rst_alu_wordA", o_alu_wordA, 32'd0);
        chk("rst_alu_opcode", 32'(o_alu_opcode), 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk("rst_cnt0", 32'(o_grant_cnt0), 32'd0);
        chk("rst_cnt1", 32'(o_grant_cnt1), 32'd0);
`endif
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("post_rst_valid", 32'(o_rsp_valid), 32'd0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_rsp_ready = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();

        // req0 alone: ADD 5+7 -> 12, id 0, one cycle later
        set_req(0, 1'b1, 4'd0, 32'd5, 32'd7, 5'd0);
        i_req1_valid = 1'b0;
        step(1'b1);
        chk("add_data", o_rsp_data, 32'd12);
        chk("add_id", 32'(o_rsp_id), 32'd0);

        // both valid every cycle: alternate starting with 0 after reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            step(1'b1);
            chk("alt_id", 32'(o_rsp_id), 32'(i % 2));
        end

        // backpressure: req1 SUB 10-3 held while rsp_ready low
        i_req0_valid = 1'b0;
        set_req(1, 1'b1, 4'd1, 32'd10, 32'd3, 5'd0);
        step(1'b1);
        chk("sub_data", o_rsp_data, 32'd7);
        i_req1_valid = 1'b0;
        set_req(0, 1'b1, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("hold_data", o_rsp_data, 32'd7);
            chk("hold_id", 32'(o_rsp_id), 32'd1);
        end
        step(1'b1);
        chk("after_hold_data", o_rsp_data, 32'h00F0_1234);
        chk("after_hold_id", 32'(o_rsp_id), 32'd0);

        // random traffic with occasional backpressure
        for (int i = 0; i < 400; i++) begin
            rand_req(0, 1'($urandom_range(0, 1)));
            rand_req(1, 1'($urandom_range(0, 1)));
            step(1'($urandom_range(0, 3) != 0));
        end

        // reset mid-FULL: fill then reset while unaccepted
        set_req(0, 1'b1, 4'd0, 32'd100, 32'd23, 5'd0);
        i_req1_valid = 1'b0;
        step(1'b1);
        i_req0_valid = 1'b0;
        step(1'b0);
        chk("pre_rst_full", 32'(o_rsp_valid), 32'd1);
        do_reset();
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        step(1'b1);
        chk("tie_after_rst_id", 32'(o_rsp_id), 32'd0);

        // long run of req0-only transfers to saturate the counter
        do_reset();
        i_req1_valid = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            rand_req(0, 1'b1);
            step(1'b1);
        end
`ifdef ALU_ARB_STATS_EN
        chk("cnt0_sat", 32'(o_grant_cnt0), 32'h0000_FFFF);
        chk("cnt1_zero", 32'(o_grant_cnt1), 32'd0);
        chk("cnt0_model", 32'(o_grant_cnt0), 32'(m_cnt0));
`endif
        i_req0_valid = 1'b0;
        step(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
